// File: rtl/wb_burst_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_burst_pkg
//  Purpose  : Shared constants and FSM encoding for the Wishbone burst master.
//  Revision : 1.0  initial release
// ============================================================================
package wb_burst_pkg;

    typedef logic [2:0] state_t;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] BUS   = 3'd2;
    localparam logic [2:0] PUSH  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [3:0] WB_SEL_ALL = 4'hF;
    localparam int         WORD_BYTES = 4;

    // Where the FSM goes after a word has completed on the bus side.
    function automatic state_t advance_to(input logic last, input logic we);
        return last ? DONE : (we ? FETCH : BUS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_timeout_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : wb_timeout_cnt
//  Purpose  : Per-transfer wait counter; expire marks the TIMEOUT-th run cycle.
//  Revision : 1.0  initial release
// ============================================================================
module wb_timeout_cnt #(
    parameter int TIMEOUT = 63
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic load,
    input  logic run,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (run && !expire) begin
            count <= count + CW'(1);
        end
    end

    assign expire = run && (count == CW'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/wb_burst_master.sv
`default_nettype none
// ============================================================================
//  Module   : wb_burst_master
//  Purpose  : Command-driven Wishbone burst master, one classic cycle per word.
//             Optional per-transfer ack timeout: WB_BURST_MASTER_TIMEOUT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module wb_burst_master #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 63
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    // command
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [7:0]        cmd_len,
    // write stream
    input  logic [31:0]       wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    // read stream
    output logic [31:0]       rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    // status
    output logic              done,
    output logic              err,
    // wishbone master
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic              wbm_we_o,
    output logic [3:0]        wbm_sel_o,
    output logic [ADDR_W-1:0] wbm_adr_o,
    output logic [31:0]       wbm_dat_o,
    input  logic [31:0]       wbm_dat_i,
    input  logic              wbm_ack_i
);

    import wb_burst_pkg::*;

    state_t            state;
    logic              burst_we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        remaining;
    logic [31:0]       dat_out;
    logic [31:0]       rd_hold;
    logic              in_bus;
    logic              last;
    logic              timed_out;

    assign in_bus = (state == BUS);
    assign last   = (remaining == 8'd1);

`ifdef WB_BURST_MASTER_TIMEOUT_EN
    logic err_flag;

    wb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .load     (!in_bus),
        .run      (in_bus),
        .expire   (timed_out)
    );

    // Ack on the expiry cycle still counts as a good transfer.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            err_flag <= 1'b0;
        end else if (state == IDLE) begin
            err_flag <= 1'b0;
        end else if (in_bus && !wbm_ack_i && timed_out) begin
            err_flag <= 1'b1;
        end
    end

    assign err = err_flag && (state == DONE);
`else
    assign timed_out = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            burst_we  <= 1'b0;
            addr      <= '0;
            remaining <= 8'd0;
            dat_out   <= 32'd0;
            rd_hold   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        burst_we  <= cmd_we;
                        addr      <= cmd_addr;
                        remaining <= (cmd_len == 8'd0) ? 8'd1 : cmd_len;
                        state     <= cmd_we ? FETCH : BUS;
                    end
                end
                FETCH: begin
                    if (wr_valid) begin
                        dat_out <= wr_data;
                        state   <= BUS;
                    end
                end
                BUS: begin
                    if (wbm_ack_i) begin
                        if (burst_we) begin
                            addr      <= addr + ADDR_W'(WORD_BYTES);
                            remaining <= remaining - 8'd1;
                            state     <= advance_to(last, burst_we);
                        end else begin
                            rd_hold <= wbm_dat_i;
                            state   <= PUSH;
                        end
                    end else if (timed_out) begin
                        state <= DONE;
                    end
                end
                PUSH: begin
                    if (rd_ready) begin
                        addr      <= addr + ADDR_W'(WORD_BYTES);
                        remaining <= remaining - 8'd1;
                        state     <= advance_to(last, burst_we);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Bus strobes decode straight from state so reset removes them at once.
    assign wbm_cyc_o = in_bus;
    assign wbm_stb_o = in_bus;
    assign wbm_we_o  = in_bus && burst_we;
    assign wbm_sel_o = in_bus ? WB_SEL_ALL : 4'h0;
    assign wbm_adr_o = addr;
    assign wbm_dat_o = dat_out;

    assign cmd_ready = (state == IDLE);
    assign wr_ready  = (state == FETCH);
    assign rd_valid  = (state == PUSH);
    assign rd_data   = rd_hold;
    assign done      = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_wb_burst_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_burst_master
//  Purpose  : Directed self-checking bench for wb_burst_master.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_burst_master;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_addr = 32'd0;
    logic [7:0]  cmd_len = 8'd0;
    logic [31:0] wr_data = 32'd0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_ready = 1'b1;
    logic        done;
    logic        err;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;

    int checks   = 0;
    int failures = 0;

    wb_burst_master #(
        .ADDR_W  (32),
        .TIMEOUT (63)
    ) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .done      (done),
        .err       (err),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_ack_i (wbm_ack_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Slave: registered ack after ack_delay waits, or same-cycle ack when zero_wait.
    int   ack_delay = 10;
    int   wcnt      = 0;
    logic ack_r     = 1'b0;
    logic zero_wait = 1'b0;
    logic stray_ack = 1'b0;

    always @(posedge wb_clk_i) begin
        if (!(wbm_cyc_o && wbm_stb_o) || ack_r) begin
            ack_r <= 1'b0;
            wcnt  <= 0;
        end else if (wcnt >= ack_delay) begin
            ack_r <= 1'b1;
        end else begin
            wcnt <= wcnt + 1;
        end
    end

    assign wbm_ack_i = (zero_wait ? (wbm_cyc_o && wbm_stb_o) : ack_r) | stray_ack;
    assign wbm_dat_i = {wbm_adr_o[15:0], ~wbm_adr_o[15:0]};

    // Observation log
    logic [31:0] adr_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] wadr_q[$];
    logic [31:0] wdat_q[$];
    int   wr_acc_cnt   = 0;
    int   done_cnt     = 0;
    int   done_err_cnt = 0;
    int   gap_viol     = 0;
    int   sel_bad      = 0;
    int   cyc_run      = 0;
    int   last_run     = 0;
    logic prev_ack     = 1'b0;

    always @(posedge wb_clk_i) begin
        if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
            adr_q.push_back(wbm_adr_o);
            if (wbm_we_o) begin
                wadr_q.push_back(wbm_adr_o);
                wdat_q.push_back(wbm_dat_o);
            end
        end
        if (rd_valid && rd_ready) rd_q.push_back(rd_data);
        if (wr_valid && wr_ready) wr_acc_cnt <= wr_acc_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (done && err) done_err_cnt <= done_err_cnt + 1;
        if (prev_ack && wbm_cyc_o) gap_viol <= gap_viol + 1;
        if (wbm_cyc_o && wbm_sel_o != 4'hF) sel_bad <= sel_bad + 1;
        prev_ack <= wbm_cyc_o && wbm_stb_o && wbm_ack_i;
        if (wbm_cyc_o) begin
            cyc_run <= cyc_run + 1;
        end else if (cyc_run != 0) begin
            last_run <= cyc_run;
            cyc_run  <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        adr_q.delete();
        rd_q.delete();
        wadr_q.delete();
        wdat_q.delete();
    endtask

    task automatic start_cmd(input logic we, input logic [31:0] a, input logic [7:0] l);
        @(negedge wb_clk_i);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = a;
        cmd_len   = l;
        @(negedge wb_clk_i);
        cmd_valid = 1'b0;
    endtask

    task automatic push_word(input string tag, input logic [31:0] d, input int delay);
        int  start;
        bit  seen;
        start = wr_acc_cnt;
        seen  = 1'b0;
        repeat (delay) @(negedge wb_clk_i);
        wr_valid = 1'b1;
        wr_data  = d;
        for (int i = 0; i < 100; i++) begin
            @(negedge wb_clk_i);
            if (wr_acc_cnt != start) begin
                seen = 1'b1;
                break;
            end
        end
        wr_valid = 1'b0;
        check(tag, 32'(seen), 32'd1);
    endtask

    // Returns at the negedge of the done cycle (or after the bound).
    task automatic wait_done(input string tag, input int max_cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge wb_clk_i);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done"}, 32'(seen), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        int  d0;
        bit  seen;

        // ---------------- reset state ----------------
        repeat (2) @(negedge wb_clk_i);
        check("rst_cyc",     32'(wbm_cyc_o), 32'd0);
        check("rst_stb",     32'(wbm_stb_o), 32'd0);
        check("rst_we",      32'(wbm_we_o),  32'd0);
        check("rst_sel",     32'(wbm_sel_o), 32'd0);
        check("rst_adr",     wbm_adr_o,      32'd0);
        check("rst_dat_o",   wbm_dat_o,      32'd0);
        check("rst_rd_data", rd_data,        32'd0);
        check("rst_rd_val",  32'(rd_valid),  32'd0);
        check("rst_wr_rdy",  32'(wr_ready),  32'd0);
        check("rst_done",    32'(done),      32'd0);
        check("rst_err",     32'(err),       32'd0);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        // ---------------- stray ack in IDLE is ignored ----------------
        d0 = done_cnt;
        stray_ack = 1'b1;
        repeat (3) @(negedge wb_clk_i);
        stray_ack = 1'b0;
        @(negedge wb_clk_i);
        check("stray_cyc",   32'(wbm_cyc_o), 32'd0);
        check("stray_ready", 32'(cmd_ready), 32'd1);
        check("stray_done",  32'(done_cnt),  32'(d0));
        check("stray_log",   32'(adr_q.size()), 32'd0);

        // ---------------- 4-word read, slave waits 10 ----------------
        clear_logs();
        ack_delay = 10;
        d0 = done_cnt;
        start_cmd(1'b0, 32'h3800_0000, 8'd4);
        wait_done("rd4", 400);
        check("rd4_err",    32'(err), 32'd0);
        check("rd4_nadr",   32'(adr_q.size()), 32'd4);
        check("rd4_adr0",   adr_q[0], 32'h3800_0000);
        check("rd4_adr1",   adr_q[1], 32'h3800_0004);
        check("rd4_adr2",   adr_q[2], 32'h3800_0008);
        check("rd4_adr3",   adr_q[3], 32'h3800_000C);
        check("rd4_nrd",    32'(rd_q.size()), 32'd4);
        check("rd4_dat0",   rd_q[0], 32'h0000_FFFF);
        check("rd4_dat1",   rd_q[1], 32'h0004_FFFB);
        check("rd4_dat2",   rd_q[2], 32'h0008_FFF7);
        check("rd4_dat3",   rd_q[3], 32'h000C_FFF3);
        repeat (3) @(negedge wb_clk_i);
        check("rd4_one_done", 32'(done_cnt - d0), 32'd1);
        check("rd4_ready",  32'(cmd_ready), 32'd1);

        // ---------------- 2-word write, data late by 3 ----------------
        clear_logs();
        ack_delay = 2;
        start_cmd(1'b1, 32'h3800_0010, 8'd2);
        check("wr_fetch_rdy", 32'(wr_ready), 32'd1);
        check("wr_fetch_cyc", 32'(wbm_cyc_o), 32'd0);
        push_word("wr_acc0", 32'hDEAD_BEEF, 3);
        push_word("wr_acc1", 32'h1234_5678, 3);
        wait_done("wr2", 200);
        check("wr2_n",    32'(wadr_q.size()), 32'd2);
        check("wr2_adr0", wadr_q[0], 32'h3800_0010);
        check("wr2_adr1", wadr_q[1], 32'h3800_0014);
        check("wr2_dat0", wdat_q[0], 32'hDEAD_BEEF);
        check("wr2_dat1", wdat_q[1], 32'h1234_5678);
        check("wr2_err",  32'(err), 32'd0);

        // ---------------- read with rd_ready held off ----------------
        clear_logs();
        ack_delay = 2;
        rd_ready  = 1'b0;
        start_cmd(1'b0, 32'h0000_0100, 8'd2);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (rd_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge wb_clk_i);
        end
        check("bp_valid_seen", 32'(seen), 32'd1);
        check("bp_data0", rd_data, 32'h0100_FEFF);
        for (int i = 0; i < 5; i++) begin
            @(negedge wb_clk_i);
            check("bp_hold_valid", 32'(rd_valid),  32'd1);
            check("bp_hold_data",  rd_data,        32'h0100_FEFF);
            check("bp_hold_cyc",   32'(wbm_cyc_o), 32'd0);
        end
        check("bp_one_xfer", 32'(adr_q.size()), 32'd1);
        rd_ready = 1'b1;
        wait_done("bp", 100);
        check("bp_nrd",  32'(rd_q.size()), 32'd2);
        check("bp_dat0", rd_q[0], 32'h0100_FEFF);
        check("bp_dat1", rd_q[1], 32'h0104_FEFB);

        // ---------------- len 0 and wrap, zero-wait ack ----------------
        clear_logs();
        zero_wait = 1'b1;
        start_cmd(1'b0, 32'hFFFF_FFFC, 8'd0);
        wait_done("len0", 50);
        check("len0_n",    32'(adr_q.size()), 32'd1);
        check("len0_adr",  adr_q[0], 32'hFFFF_FFFC);
        check("len0_dat",  rd_q[0],  32'hFFFC_0003);
        check("len0_run",  32'(last_run), 32'd1);
        clear_logs();
        @(negedge wb_clk_i);
        start_cmd(1'b0, 32'hFFFF_FFFC, 8'd2);
        wait_done("wrap", 50);
        check("wrap_n",    32'(adr_q.size()), 32'd2);
        check("wrap_adr0", adr_q[0], 32'hFFFF_FFFC);
        check("wrap_adr1", adr_q[1], 32'h0000_0000);
        check("wrap_dat1", rd_q[1],  32'h0000_FFFF);
        zero_wait = 1'b0;

        // ---------------- ack timeout / indefinite wait ----------------
        clear_logs();
        ack_delay = 1000;
`ifdef WB_BURST_MASTER_TIMEOUT_EN
        d0 = done_err_cnt;
        start_cmd(1'b0, 32'h0000_0300, 8'd4);
        wait_done("tmo", 200);
        check("tmo_err",  32'(err), 32'd1);
        check("tmo_cyc",  32'(wbm_cyc_o), 32'd0);
        @(negedge wb_clk_i);
        check("tmo_run",   32'(last_run), 32'd63);
        check("tmo_ready", 32'(cmd_ready), 32'd1);
        check("tmo_pulse", 32'(done), 32'd0);
        check("tmo_err_pulse", 32'(err), 32'd0);
        check("tmo_pair",  32'(done_err_cnt - d0), 32'd1);
        check("tmo_noack", 32'(adr_q.size()), 32'd0);
`else
        start_cmd(1'b0, 32'h0000_0300, 8'd1);
        repeat (70) @(negedge wb_clk_i);
        check("wait_cyc",  32'(wbm_cyc_o), 32'd1);
        check("wait_done", 32'(done), 32'd0);
        ack_delay = 0;
        wait_done("wait", 20);
        check("wait_err",  32'(err), 32'd0);
        check("wait_dat",  rd_q[0], 32'h0300_FCFF);
`endif
        ack_delay = 10;

        // ---------------- reset during BUS ----------------
        clear_logs();
        ack_delay = 30;
        start_cmd(1'b0, 32'h0000_0200, 8'd4);
        repeat (3) @(negedge wb_clk_i);
        check("mid_cyc_before", 32'(wbm_cyc_o), 32'd1);
        d0 = done_cnt;
        #1;
        wb_rst_i = 1'b1;
        #1;
        check("mid_cyc_async", 32'(wbm_cyc_o), 32'd0);
        check("mid_stb_async", 32'(wbm_stb_o), 32'd0);
        repeat (2) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        check("mid_ready", 32'(cmd_ready), 32'd1);
        repeat (40) @(negedge wb_clk_i);
        check("mid_no_done", 32'(done_cnt - d0), 32'd0);
        check("mid_idle_cyc", 32'(wbm_cyc_o), 32'd0);
        check("mid_no_xfer", 32'(adr_q.size()), 32'd0);

        // ---------------- bus protocol invariants ----------------
        check("gap_between_xfers", 32'(gap_viol), 32'd0);
        check("sel_all_in_bus",    32'(sel_bad),  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_burst_master.md
WB_BURST_MASTER -- requirements
Module: wb_burst_master

Interface
REQ-001 Parameters: ADDR_W, default 32, Wishbone address width.
REQ-002 Parameters: TIMEOUT, default 63, maximum wait cycles for wbm_ack_i per transfer.
REQ-003 The clock SHALL be wb_clk_i  in  1  rising-edge clock for all state.
REQ-004 The reset SHALL be wb_rst_i  in  1  asynchronous, active-high reset.
REQ-005 Command ports SHALL be: cmd_valid in 1; cmd_ready out 1; cmd_we in 1 (1=write burst); cmd_addr in 32 (byte address, word aligned); cmd_len in 8 (word count, 0 treated as 1).
REQ-006 The write stream SHALL be: wr_data in 32; wr_valid in 1; wr_ready out 1.
REQ-007 The read stream SHALL be: rd_data out 32; rd_valid out 1; rd_ready in 1.
REQ-008 Status ports SHALL be: done out 1 (one-cycle pulse); err out 1 (one-cycle pulse with done on timeout).
REQ-009 Wishbone master ports SHALL be: wbm_cyc_o, wbm_stb_o, wbm_we_o out 1; wbm_sel_o out 4; wbm_adr_o out 32; wbm_dat_o out 32; wbm_dat_i in 32; wbm_ack_i in 1.

Function
REQ-010 FSM states SHALL be IDLE, FETCH, BUS, PUSH, DONE.
REQ-011 IDLE: cmd_ready=1; on cmd_valid, latch we/addr/len and go to FETCH for writes, BUS for reads.
REQ-012 FETCH: wr_ready=1; on wr_valid, latch wr_data into wbm_dat_o, go to BUS.
REQ-013 BUS: cyc=stb=1, sel=4'hF, we=latched we, adr=current address; held stable until ack.
REQ-014 On wbm_ack_i in BUS: cyc/stb drop next cycle; reads capture wbm_dat_i into rd_data and go to PUSH; writes advance.
REQ-015 PUSH: rd_valid=1 with rd_data stable until rd_ready; then advance.
REQ-016 Advance: address += 4, remaining count -= 1; remaining 0 -> DONE, else FETCH (write) or BUS (read).
REQ-017 Address increment SHALL wrap modulo 2^32; no boundary check.
REQ-018 DONE: done=1 for one cycle, then IDLE; cmd_ready=0 in every state except IDLE.
REQ-019 wbm_ack_i outside BUS SHALL be ignored; ack in the first BUS cycle SHALL be accepted (minimum 1 wait-free cycle).
REQ-020 A burst of N words SHALL take N Wishbone cycles, each with cyc/stb deasserted for at least one cycle between transfers.

Reset
REQ-021 On wb_rst_i: state IDLE; cyc, stb, we, rd_valid, wr_ready, done, err = 0; sel, adr, dat_o, rd_data = 0.
REQ-022 Reset mid-burst SHALL drop cyc/stb immediately (asynchronously) and discard the remaining burst without done.

Configuration
REQ-023 Macro WB_BURST_MASTER_TIMEOUT_EN defined: a counter runs in BUS; on reaching TIMEOUT without ack, drop cyc/stb, abort burst, pulse done and err together, return to IDLE.
REQ-024 Without WB_BURST_MASTER_TIMEOUT_EN: BUS waits indefinitely; err tied 0; no timeout counter logic.

Structure
REQ-025 Shared package wb_burst_pkg SHALL hold the FSM state encoding, WB_SEL_ALL=4'hF and WORD_BYTES=4.
REQ-026 Sub-module wb_timeout_cnt (load/run/expire) SHALL implement the timeout counter, instantiated only under the macro.

Verification
REQ-027 Read 4 words from 0x3800_0000, slave acks after 10 cycles -> adr 0x3800_0000/04/08/0C, rd_data matches slave, one done pulse, err=0.
REQ-028 Write 2 words (0xDEADBEEF, 0x12345678) to 0x3800_0010 with wr_valid delayed 3 cycles -> we=1, dat_o matches, cyc low between transfers.
REQ-029 Read with rd_ready held low 5 cycles -> rd_valid and rd_data stable, no new Wishbone cycle until accepted.
REQ-030 Macro on, TIMEOUT=63, slave never acks -> cyc/stb drop after 63 cycles, done=err=1 for one cycle, cmd_ready=1 next cycle.
REQ-031 cmd_len=0 at address 0xFFFF_FFFC, then cmd_len=2 -> first performs one transfer; second wraps to 0x0000_0000.
REQ-032 Assert wb_rst_i during BUS of a 4-word read -> cyc/stb low immediately, no done, cmd_ready=1 after release.
